reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-dependency scoreboard for the decode stage of the pipelined processor. Tracks outstanding writes to each of the 32 architectural registers, selects the instruction's destination register (rt or rd), and raises a stall when a decoding instruction reads or overwrites a register with a pending write that cannot be satisfied. Sits between the decoder and the ID/EX pipeline register. Writeback reports completed writes back into the block.

## Interface
- MAX_INFLIGHT, 3: maximum outstanding writes tracked per register; must be ≤ 2^CNT_W − 1.
- CNT_W, 2: width of each per-register pending counter.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs, id_rt, id_rd  in  5 each  register fields of the decoding instruction.
- id_uses_rs, id_uses_rt  in  1 each  instruction reads rs / rt.
- id_writes_reg  in  1  instruction writes a register.
- id_reg_dst  in  1  destination select: 0 = rt, 1 = rd.
- wb_valid  in  1  writeback commits a register write this cycle.
- wb_dest  in  5  register written by writeback.
- id_dest  out  5  selected destination register (combinational).
- stall  out  1  hold decode and insert a bubble (combinational).
- issue  out  1  instruction accepted this cycle: id_valid & ~stall.
- pending_any  out  1  registered; at least one counter nonzero.

## Operation
- Per-register counters cnt[0..31], CNT_W bits. cnt[0] is hard-wired 0; writes to and reads of r0 never pend and never stall.
- id_dest = id_reg_dst ? id_rd : id_rt. This is the 5-bit 2:1 select. It is meaningful only when id_writes_reg is set.
- Effective count: eff[r] = cnt[r] − (wb_valid & wb_dest==r & r≠0). Writeback completes in the first half-cycle, so a same-cycle commit clears the hazard.
- Stall is asserted when id_valid is set and any of the following holds:
  - RAW on rs: id_uses_rs & eff[id_rs]≠0.
  - RAW on rt: id_uses_rt & eff[id_rt]≠0.
  - Saturation: id_writes_reg & id_dest≠0 & eff[id_dest]==MAX_INFLIGHT.
- Counter update on each rising edge:
  - Increment by 1: issue & id_writes_reg & id_dest==r & r≠0.
  - Decrement by 1: wb_valid & wb_dest==r & r≠0.
  - Both on the same register: unchanged.
- wb_valid to a register with cnt==0 is a protocol error. The counter holds at 0 and does not underflow. The bench flags this with an assertion.
- Unrelated registers update independently in the same cycle.

## Timing
- Reset (reset_n low, asynchronous): all cnt = 0 and pending_any = 0. While in reset, stall = 0 and issue follows id_valid. Reset asserted mid-operation discards all pending state immediately.
- stall, issue and id_dest are combinational, with zero latency from the id_* and wb_* inputs.
- An issued write is visible as a hazard to the very next instruction, one cycle later.
- A writeback on cycle N unblocks a stalled reader in cycle N itself, through the bypass.
- pending_any reflects counter state after the edge.

## Structure
- Shared package holds REG_ADDR_W=5, NUM_REGS=32 and REG_ZERO=5'd0. The decoder and writeback stage use the same constants.
- Destination selection instantiates the existing mux_2_1_5_bit (line0=id_rt, line1=id_rd, select=id_reg_dst).
- Counters live in a generate loop over r=1..31 inside this module. No further sub-modules.

## Test plan
- Reset: reset_n=0 with id_valid=1, id_uses_rs=1, id_rs=5 → stall=0, pending_any=0. After release, same stimulus → stall=0.
- RAW stall and release:
  - Issue a write to r8 (reg_dst=1, rd=8); next cycle read rs=8 → stall=1.
  - Then wb_valid=1, wb_dest=8 in that cycle → stall=0 the same cycle and issue=1.
- r0 immunity: issue a write with rd=0, then read rs=0 and rt=0 → stall=0 and pending_any stays 0.
- Saturation: three back-to-back issues writing r3 (rt=3, reg_dst=0) → cnt[3]=3. A fourth write to r3 → stall=1. A wb to r3 in that cycle → issue=1, and cnt[3] stays 3.
- Simultaneous events: same cycle, issue writes r4 and wb commits r4 (cnt[4]=1 beforehand) → cnt[4] remains 1. Issue writes r6 while wb commits r7 → r6 increments and r7 decrements.
- Mid-operation reset: r9 and r10 pending, pulse reset_n low between edges → all cnt=0 and pending_any=0 immediately. A read of r9 after release → stall=0.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard_pkg
//  Brief    : Register-file constants shared by decode, scoreboard and
//             writeback, plus a small helper for r0 detection.
//  Revision : 1.0  initial release
// ============================================================================
package reg_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // r0 is hard-wired zero and never participates in hazards.
  function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] r);
    return (r != REG_ZERO);
  endfunction

endpackage : reg_scoreboard_pkg
`default_nettype wire

// File: rtl/mux_2_1_5_bit.sv
`default_nettype none
// ============================================================================
//  Module   : mux_2_1_5_bit
//  Brief    : 5-bit 2:1 multiplexer (select=0 -> line0, select=1 -> line1).
//  Revision : 1.0  initial release
// ============================================================================
module mux_2_1_5_bit (
  input  logic [4:0] line0,
  input  logic [4:0] line1,
  input  logic       select,
  output logic [4:0] line_out
);

  assign line_out = select ? line1 : line0;

endmodule : mux_2_1_5_bit
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Brief    : Decode-stage register-dependency scoreboard. Keeps a pending
//             write counter per architectural register, selects the
//             destination register and stalls on RAW hazards or when a
//             destination already has MAX_INFLIGHT writes outstanding.
//             Same-cycle writeback is bypassed into the hazard check.
//  Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_writes_reg,
  input  logic                  id_reg_dst,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  output logic [REG_ADDR_W-1:0] id_dest,
  output logic                  stall,
  output logic                  issue,
  output logic                  pending_any
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  // Flattened views: current counters and bypass-adjusted effective counts.
  logic [NUM_REGS*CNT_W-1:0] cnt_all;
  logic [NUM_REGS*CNT_W-1:0] eff_all;
  logic [NUM_REGS-1:0]       nxt_nonzero;

  logic [CNT_W-1:0] eff_rs;
  logic [CNT_W-1:0] eff_rt;
  logic [CNT_W-1:0] eff_dest;
  logic             raw_rs;
  logic             raw_rt;
  logic             sat_dest;

  // Destination register select (rt or rd).
  mux_2_1_5_bit u_dest_mux (
    .line0    (id_rt),
    .line1    (id_rd),
    .select   (id_reg_dst),
    .line_out (id_dest)
  );

  // r0 never holds a pending write.
  assign cnt_all[CNT_W-1:0] = '0;
  assign eff_all[CNT_W-1:0] = '0;
  assign nxt_nonzero[0]     = 1'b0;

  // Effective counts of the three registers the decoding instruction touches.
  assign eff_rs   = eff_all[id_rs   * CNT_W +: CNT_W];
  assign eff_rt   = eff_all[id_rt   * CNT_W +: CNT_W];
  assign eff_dest = eff_all[id_dest * CNT_W +: CNT_W];

  assign raw_rs   = id_uses_rs & (eff_rs != '0);
  assign raw_rt   = id_uses_rt & (eff_rt != '0);
  assign sat_dest = id_writes_reg & is_real_reg(id_dest) & (eff_dest == MAX_CNT);

  assign stall = id_valid & (raw_rs | raw_rt | sat_dest);
  assign issue = id_valid & ~stall;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             inc;
    logic             dec;

    assign inc = issue & id_writes_reg & (id_dest == REG_ADDR_W'(r));
    // A writeback to an idle register is a protocol error; ignoring it keeps
    // the counter from underflowing.
    assign dec = wb_valid & (wb_dest == REG_ADDR_W'(r)) & (cnt_q != '0);

    // Next counter value: simultaneous inc and dec cancel.
    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec) begin
        cnt_d = cnt_q + 1'b1;
      end else if (dec && !inc) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    // Per-register pending counter.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_all[r*CNT_W +: CNT_W] = cnt_q;
    assign eff_all[r*CNT_W +: CNT_W] = cnt_q - {{(CNT_W-1){1'b0}}, dec};
    assign nxt_nonzero[r]            = (cnt_d != '0);
  end : g_cnt

  // Registered summary of the post-edge counter state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_any <= 1'b0;
    end else begin
      pending_any <= |nxt_nonzero;
    end
  end

endmodule : reg_scoreboard
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_scoreboard
//  Brief    : Directed self-checking bench for reg_scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       id_valid, id_uses_rs, id_uses_rt, id_writes_reg, id_reg_dst;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       wb_valid;
  logic [4:0] wb_dest;
  logic [4:0] id_dest;
  logic       stall, issue, pending_any;

  int errors = 0;
  int checks = 0;

  reg_scoreboard #(.MAX_INFLIGHT(3), .CNT_W(2)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_writes_reg (id_writes_reg),
    .id_reg_dst    (id_reg_dst),
    .wb_valid      (wb_valid),
    .wb_dest       (wb_dest),
    .id_dest       (id_dest),
    .stall         (stall),
    .issue         (issue),
    .pending_any   (pending_any)
  );

  always #5 clock = ~clock;

  // Writeback must never target a register with nothing outstanding.
  always @(posedge clock) begin
    if (reset_n && wb_valid && wb_dest != 5'd0) begin
      assert (dut.cnt_all[wb_dest*2 +: 2] != 2'd0)
        else $error("protocol: writeback to idle register %0d", wb_dest);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_writes_reg = 0;
    id_reg_dst = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    wb_valid = 0; wb_dest = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] r);
    idle();
    id_valid = 1; id_writes_reg = 1; id_reg_dst = 1; id_rd = r;
  endtask

  task automatic read_rs(input logic [4:0] r);
    idle();
    id_valid = 1; id_uses_rs = 1; id_rs = r;
  endtask

  initial begin
    idle();
    reset_n = 0;
    // Reset: reader of r5 must not stall, issue follows id_valid.
    read_rs(5'd5);
    #1;
    check("rst_stall", stall, 0);
    check("rst_issue", issue, 1);
    check("rst_pending", pending_any, 0);
    tick(); tick();
    reset_n = 1;
    #1;
    check("post_rst_stall", stall, 0);
    tick();

    // RAW on r8, then same-cycle writeback bypass.
    write_reg(5'd8);
    #1;
    check("w8_dest", id_dest, 8);
    check("w8_issue", issue, 1);
    tick();
    check("w8_pending", pending_any, 1);
    read_rs(5'd8);
    #1;
    check("raw8_stall", stall, 1);
    check("raw8_issue", issue, 0);
    wb_valid = 1; wb_dest = 5'd8;
    #1;
    check("raw8_bypass_stall", stall, 0);
    check("raw8_bypass_issue", issue, 1);
    tick();
    check("raw8_drained", pending_any, 0);

    // r0 immunity.
    write_reg(5'd0);
    #1;
    check("r0_dest", id_dest, 0);
    check("r0_issue", issue, 1);
    tick();
    check("r0_pending", pending_any, 0);
    idle();
    id_valid = 1; id_uses_rs = 1; id_uses_rt = 1;
    #1;
    check("r0_read_stall", stall, 0);
    tick();

    // Saturation on r3 via rt destination.
    idle();
    id_valid = 1; id_writes_reg = 1; id_reg_dst = 0; id_rt = 5'd3; id_rd = 5'd7;
    #1;
    check("sat_dest_rt", id_dest, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sat_issue%0d", i), issue, 1);
      tick();
    end
    check("sat_full_stall", stall, 1);
    wb_valid = 1; wb_dest = 5'd3;
    #1;
    check("sat_wb_issue", issue, 1);
    tick();
    wb_valid = 0;
    #1;
    check("sat_still_full", stall, 1);
    idle();
    wb_valid = 1; wb_dest = 5'd3;
    tick(); tick(); tick();
    idle();
    #1;
    check("sat_drained", pending_any, 0);

    // Simultaneous events: inc+dec on r4 cancels.
    write_reg(5'd4); tick();
    write_reg(5'd7); tick();
    write_reg(5'd4);
    wb_valid = 1; wb_dest = 5'd4;
    #1;
    check("sim4_issue", issue, 1);
    tick();
    read_rs(5'd4);
    #1;
    check("sim4_pending", stall, 1);
    wb_valid = 1; wb_dest = 5'd4;
    #1;
    check("sim4_exactly_one", stall, 0);
    tick();
    // Issue to r6 while r7 retires.
    write_reg(5'd6);
    wb_valid = 1; wb_dest = 5'd7;
    tick();
    read_rs(5'd6);
    #1;
    check("sim6_inc", stall, 1);
    read_rs(5'd7);
    #1;
    check("sim7_dec", stall, 0);
    check("sim_pending", pending_any, 1);
    idle();
    wb_valid = 1; wb_dest = 5'd6;
    tick();
    idle();
    #1;
    check("sim_drained", pending_any, 0);

    // Mid-operation asynchronous reset with r9 and r10 pending.
    write_reg(5'd9);  tick();
    write_reg(5'd10); tick();
    read_rs(5'd9);
    #1;
    check("mid_pre_stall", stall, 1);
    check("mid_pre_pending", pending_any, 1);
    #1;
    reset_n = 0;
    #1;
    check("mid_rst_pending", pending_any, 0);
    check("mid_rst_stall", stall, 0);
    reset_n = 1;
    #1;
    check("mid_rel_stall", stall, 0);
    tick();
    idle();
    id_valid = 1; id_uses_rs = 1; id_rs = 5'd9; id_uses_rt = 1; id_rt = 5'd10;
    #1;
    check("mid_after_stall", stall, 0);
    check("mid_after_pending", pending_any, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_reg_scoreboard
`default_nettype wire
